// File: rtl/uut_result_packer.sv
// Times one UUT run in clk cycles and serves the result as an 8-byte record
// (count MSB first, status, two pad bytes, XOR checksum), one byte per request.
module uut_result_packer #(
   parameter int          COUNT_WIDTH    = 32,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   clear,
   input  logic                   end_uut,
   input  logic                   err_uut,
   output logic                   busy,
   output logic                   rec_ready,
   output logic                   timed_out,
   output logic [COUNT_WIDTH-1:0] cycles,
   input  logic                   byte_req,
   output logic [7:0]             byte_data,
   output logic                   byte_valid,
   output logic                   byte_last
);

   typedef enum logic [1:0] {IDLE, RUN, DONE, SEND} state_t;

   state_t                 state_q, state_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d, count_inc;
   logic [COUNT_WIDTH-1:0] cycles_q, cycles_d;
   logic                   timed_out_q, timed_out_d;
   logic                   end_q, end_d, err_q, err_d;
   logic [2:0]             idx_q, idx_d;
   logic [7:0]             byte_data_q, byte_data_d;
   logic                   byte_valid_q, byte_valid_d;
   logic                   byte_last_q, byte_last_d;
   logic [7:0]             status;
   logic [7:0]             cksum;
   logic [63:0]            rec;
   logic                   tmo_hit;

   assign count_inc = (&count_q) ? count_q : count_q + COUNT_WIDTH'(1);
   assign tmo_hit   = (TIMEOUT_CYCLES != 32'd0) && (count_inc == COUNT_WIDTH'(TIMEOUT_CYCLES));

   assign status = {5'b0, timed_out_q, err_q, end_q};
   assign cksum  = cycles_q[31:24] ^ cycles_q[23:16] ^ cycles_q[15:8] ^ cycles_q[7:0] ^ status;
   assign rec    = {cycles_q, status, 16'h0000, cksum};

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      cycles_d     = cycles_q;
      timed_out_d  = timed_out_q;
      end_d        = end_q;
      err_d        = err_q;
      idx_d        = idx_q;
      byte_data_d  = byte_data_q;
      byte_valid_d = 1'b0;
      byte_last_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               count_d     = '0;
               timed_out_d = 1'b0;
               state_d     = RUN;
            end
         end
         RUN: begin
            count_d = count_inc;
            // A UUT completion in the timeout cycle is a real result, not a hang.
            if (end_uut || err_uut) begin
               cycles_d = count_inc;
               end_d    = end_uut;
               err_d    = err_uut;
               state_d  = DONE;
            end else if (tmo_hit) begin
               cycles_d    = COUNT_WIDTH'(TIMEOUT_CYCLES);
               timed_out_d = 1'b1;
               end_d       = 1'b0;
               err_d       = 1'b0;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (byte_req) begin
               byte_data_d  = rec[63:56];
               byte_valid_d = 1'b1;
               idx_d        = 3'd1;
               state_d      = SEND;
            end
         end
         SEND: begin
            // Byte 7 is on the bus this cycle; the record is fully drained.
            if (byte_last_q) begin
               state_d = IDLE;
               idx_d   = 3'd0;
            end else if (byte_req) begin
               byte_data_d  = rec[{3'd7 - idx_q, 3'b000} +: 8];
               byte_valid_d = 1'b1;
               byte_last_d  = (idx_q == 3'd7);
               idx_d        = idx_q + 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state_q      <= IDLE;
         count_q      <= '0;
         cycles_q     <= '0;
         timed_out_q  <= 1'b0;
         end_q        <= 1'b0;
         err_q        <= 1'b0;
         idx_q        <= 3'd0;
         byte_data_q  <= 8'h00;
         byte_valid_q <= 1'b0;
         byte_last_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         cycles_q     <= cycles_d;
         timed_out_q  <= timed_out_d;
         end_q        <= end_d;
         err_q        <= err_d;
         idx_q        <= idx_d;
         byte_data_q  <= byte_data_d;
         byte_valid_q <= byte_valid_d;
         byte_last_q  <= byte_last_d;
      end
   end

   assign busy       = (state_q == RUN);
   assign rec_ready  = (state_q == DONE) || (state_q == SEND);
   assign timed_out  = timed_out_q;
   assign cycles     = cycles_q;
   assign byte_data  = byte_data_q;
   assign byte_valid = byte_valid_q;
   assign byte_last  = byte_last_q;

endmodule

// File: tb/tb_uut_result_packer.sv
// Bench for uut_result_packer: fixed record vectors, clear/abort sequence and
// randomized runs against a record model, on a long-timeout and a 16-cycle-timeout instance.
module tb_uut_result_packer;

   logic clk = 1'b0;
   logic rst, start, clear, end_uut, err_uut, byte_req;
   logic sel;

   logic        busy_a, rec_ready_a, timed_out_a, byte_valid_a, byte_last_a;
   logic [31:0] cycles_a;
   logic [7:0]  byte_data_a;
   logic        busy_b, rec_ready_b, timed_out_b, byte_valid_b, byte_last_b;
   logic [31:0] cycles_b;
   logic [7:0]  byte_data_b;

   logic        busy_m, rec_ready_m, timed_out_m, byte_valid_m, byte_last_m;
   logic [31:0] cycles_m;
   logic [7:0]  byte_data_m;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   uut_result_packer #(.COUNT_WIDTH(32), .TIMEOUT_CYCLES(32'd100000000)) u_a (
      .clk(clk), .rst(rst), .start(start), .clear(clear), .end_uut(end_uut), .err_uut(err_uut),
      .busy(busy_a), .rec_ready(rec_ready_a), .timed_out(timed_out_a), .cycles(cycles_a),
      .byte_req(byte_req), .byte_data(byte_data_a), .byte_valid(byte_valid_a), .byte_last(byte_last_a));

   uut_result_packer #(.COUNT_WIDTH(32), .TIMEOUT_CYCLES(32'd16)) u_b (
      .clk(clk), .rst(rst), .start(start), .clear(clear), .end_uut(end_uut), .err_uut(err_uut),
      .busy(busy_b), .rec_ready(rec_ready_b), .timed_out(timed_out_b), .cycles(cycles_b),
      .byte_req(byte_req), .byte_data(byte_data_b), .byte_valid(byte_valid_b), .byte_last(byte_last_b));

   assign busy_m       = sel ? busy_b       : busy_a;
   assign rec_ready_m  = sel ? rec_ready_b  : rec_ready_a;
   assign timed_out_m  = sel ? timed_out_b  : timed_out_a;
   assign cycles_m     = sel ? cycles_b     : cycles_a;
   assign byte_data_m  = sel ? byte_data_b  : byte_data_a;
   assign byte_valid_m = sel ? byte_valid_b : byte_valid_a;
   assign byte_last_m  = sel ? byte_last_b  : byte_last_a;

   typedef struct {
      int          k;        // cycles from start to end/err; 0 = UUT never finishes
      bit          e;
      bit          r;
      bit          sel;      // 1 = 16-cycle-timeout instance
      bit          restart;  // extra start and byte_req pulses mid-run
      bit          gap;      // idle cycle between byte requests
      logic [63:0] exp;
   } vec_t;

   vec_t tv[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Record from the rules: count (or the timeout length if the run hung), status, pad, XOR.
   function automatic logic [63:0] model(input int k, input bit e, input bit r, input int tmo);
      logic [31:0] cyc;
      logic [7:0]  st, ck;
      logic [63:0] rr;
      if (tmo != 0 && (k == 0 || k > tmo)) begin
         cyc = tmo;
         st  = 8'h04;
      end else begin
         cyc = k;
         st  = {6'b0, r, e};
      end
      rr = {cyc, st, 24'h000000};
      ck = 8'h00;
      for (int b = 0; b < 7; b++) ck = ck ^ rr[63-8*b -: 8];
      rr[7:0] = ck;
      return rr;
   endfunction

   task automatic run_meas(input int k, input bit e, input bit r, input bit restart,
                           input logic [31:0] exp_cyc, input logic exp_to);
      int lat, limit;
      bit done, busy_ok;
      clear = 1'b1; step; clear = 1'b0;
      start = 1'b1; step; start = 1'b0;
      limit   = (k == 0) ? 2000 : k;
      lat     = -1;
      done    = 1'b0;
      busy_ok = 1'b1;
      for (int j = 1; j <= limit; j++) begin
         if (rec_ready_m) begin
            lat  = j - 1;
            done = 1'b1;
            break;
         end
         if (busy_m !== 1'b1) busy_ok = 1'b0;
         start    = restart && (j == 2);
         byte_req = restart && (j == 3);
         end_uut  = e && (j == k);
         err_uut  = r && (j == k);
         step;
      end
      start = 1'b0; byte_req = 1'b0; end_uut = 1'b0; err_uut = 1'b0;
      if (!done && rec_ready_m) lat = limit;
      chk("run_latency", lat, exp_cyc);
      chk("busy_during_run", {31'b0, busy_ok}, 32'd1);
      chk("rec_ready_done", {31'b0, rec_ready_m}, 32'd1);
      chk("busy_done", {31'b0, busy_m}, 32'd0);
      chk("cycles", cycles_m, exp_cyc);
      chk("timed_out", {31'b0, timed_out_m}, {31'b0, exp_to});
   endtask

   task automatic read_rec(input logic [63:0] exp, input bit gap, input int nb);
      for (int i = 0; i < nb; i++) begin
         byte_req = 1'b1;
         step;
         if (gap) byte_req = 1'b0;
         chk($sformatf("byte%0d_valid", i), {31'b0, byte_valid_m}, 32'd1);
         chk($sformatf("byte%0d_data", i), {24'b0, byte_data_m}, {24'b0, exp[63-8*i -: 8]});
         chk($sformatf("byte%0d_last", i), {31'b0, byte_last_m}, {31'b0, (i == 7)});
         if (gap) begin
            step;
            chk($sformatf("byte%0d_gap_valid", i), {31'b0, byte_valid_m}, 32'd0);
         end
      end
      byte_req = 1'b0;
      if (nb == 8) begin
         if (!gap) begin
            step;
            chk("after_rec_valid", {31'b0, byte_valid_m}, 32'd0);
         end
         chk("after_rec_ready", {31'b0, rec_ready_m}, 32'd0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] ex;
      int k, st;
      bit s;
      rst = 1'b1; start = 1'b0; clear = 1'b0; end_uut = 1'b0; err_uut = 1'b0; byte_req = 1'b0;
      sel = 1'b0;

      tv[0] = '{5,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h00000005_01000004};
      tv[1] = '{300, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0000012C_0200002F};
      tv[2] = '{0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h00000010_04000014};
      tv[3] = '{16,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 64'h00000010_01000011};
      tv[4] = '{7,   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h00000007_03000004};
      tv[5] = '{15,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0000000F_0200000D};

      // reset state, and byte_req in IDLE gets no answer
      step; step; step;
      rst = 1'b0;
      step;
      for (int i = 0; i < 2; i++) begin
         sel = i[0];
         chk("rst_busy", {31'b0, busy_m}, 32'd0);
         chk("rst_rec_ready", {31'b0, rec_ready_m}, 32'd0);
         chk("rst_timed_out", {31'b0, timed_out_m}, 32'd0);
         chk("rst_cycles", cycles_m, 32'd0);
         chk("rst_byte_data", {24'b0, byte_data_m}, 32'd0);
         chk("rst_byte_valid", {31'b0, byte_valid_m}, 32'd0);
         chk("rst_byte_last", {31'b0, byte_last_m}, 32'd0);
      end
      sel = 1'b0;
      byte_req = 1'b1; step; byte_req = 1'b0;
      chk("idle_req_valid", {31'b0, byte_valid_m}, 32'd0);
      step;
      chk("idle_req_valid2", {31'b0, byte_valid_m}, 32'd0);
      chk("idle_req_rec_ready", {31'b0, rec_ready_m}, 32'd0);

      for (int i = 0; i < 6; i++) begin
         sel = tv[i].sel;
         run_meas(tv[i].k, tv[i].e, tv[i].r, tv[i].restart, tv[i].exp[63:32], tv[i].exp[26]);
         read_rec(tv[i].exp, tv[i].gap, 8);
      end

      // clear mid-SEND, then a fresh record from byte 0
      sel = 1'b0;
      run_meas(9, 1'b1, 1'b0, 1'b0, 32'd9, 1'b0);
      read_rec(64'h00000009_01000008, 1'b0, 3);
      clear = 1'b1; step; clear = 1'b0;
      chk("clear_rec_ready", {31'b0, rec_ready_m}, 32'd0);
      chk("clear_cycles", cycles_m, 32'd0);
      chk("clear_busy", {31'b0, busy_m}, 32'd0);
      chk("clear_valid", {31'b0, byte_valid_m}, 32'd0);
      run_meas(4, 1'b0, 1'b1, 1'b0, 32'd4, 1'b0);
      read_rec(64'h00000004_02000006, 1'b0, 8);

      // start in DONE is ignored and the record is unchanged
      run_meas(3, 1'b1, 1'b0, 1'b0, 32'd3, 1'b0);
      start = 1'b1; step; start = 1'b0; step;
      chk("done_start_ignored_busy", {31'b0, busy_m}, 32'd0);
      chk("done_start_ignored_cycles", cycles_m, 32'd3);
      read_rec(64'h00000003_01000002, 1'b1, 8);

      for (int n = 0; n < 12; n++) begin
         s   = $urandom_range(0, 1);
         sel = s;
         k   = s ? $urandom_range(1, 30) : $urandom_range(1, 200);
         st  = $urandom_range(1, 3);
         ex  = model(k, st[0], st[1], s ? 16 : 100000000);
         run_meas(k, st[0], st[1], $urandom_range(0, 1), ex[63:32], ex[26]);
         read_rec(ex, $urandom_range(0, 1), 8);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
